// File: rtl/voting_machine_n.sv
// N-candidate voting FSM: counts one vote per clean button release, locks out
// for HOLD_CYC cycles after each vote, and publishes totals/winner/tie at close.
module voting_machine_n #(
  parameter int unsigned N_CAND   = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned HOLD_CYC = 16,
  localparam int unsigned IDX_W   = (N_CAND > 2) ? $clog2(N_CAND) : 1,
  localparam int unsigned TOT_W   = CNT_W + IDX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CAND-1:0]         i_candidate,
  input  logic                      i_voting_over,
  output logic [N_CAND*CNT_W-1:0]   o_count,
  output logic [TOT_W-1:0]          o_total,
  output logic [IDX_W-1:0]          o_winner,
  output logic                      o_tie,
  output logic                      o_valid,
  output logic                      o_vote_ack,
  output logic                      o_reject,
  output logic [1:0]                o_state
);

  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StVote   = 2'd1,
    StHold   = 2'd2,
    StFinish = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [N_CAND-1:0]   prev_q;
  logic [N_CAND-1:0]   fall;
  logic [HOLD_W-1:0]   hold_q;
  logic [CNT_W-1:0]    cnt_q [N_CAND];
  logic                single_fall, in_vote, accept, reject, load;
  logic [TOT_W-1:0]    sum;
  logic [CNT_W-1:0]    max_cnt;
  logic [IDX_W-1:0]    win_idx;
  logic                tie;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!i_voting_over) state_d = StVote;
      StVote: begin
        if (i_voting_over) state_d = StFinish;
        else if (accept)   state_d = StHold;
      end
      StHold: begin
        if (i_voting_over)          state_d = StFinish;
        else if (hold_q == HOLD_LAST) state_d = StVote;
      end
      StFinish: if (!i_voting_over) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    fall        = prev_q & ~i_candidate;
    // A power of two has exactly one bit set.
    single_fall = (fall != '0) && ((fall & (fall - N_CAND'(1))) == '0);
    in_vote     = (state_q == StVote) && !i_voting_over;
    accept      = in_vote && single_fall && (i_candidate == '0);
    reject      = in_vote && (fall != '0) && !accept;
    load        = (state_q == StFinish) && !o_valid;
    o_state     = state_q;
  end

  // Strict '>' keeps the lowest index among equal maxima.
  always_comb begin
    sum     = '0;
    max_cnt = cnt_q[0];
    win_idx = '0;
    tie     = 1'b0;
    for (int unsigned k = 0; k < N_CAND; k++) begin
      sum = sum + TOT_W'(cnt_q[k]);
    end
    for (int unsigned k = 1; k < N_CAND; k++) begin
      if (cnt_q[k] > max_cnt) begin
        max_cnt = cnt_q[k];
        win_idx = IDX_W'(k);
        tie     = 1'b0;
      end else if (cnt_q[k] == max_cnt) begin
        tie = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      hold_q     <= '0;
      o_vote_ack <= 1'b0;
      o_reject   <= 1'b0;
      o_valid    <= 1'b0;
      o_count    <= '0;
      o_total    <= '0;
      o_winner   <= '0;
      o_tie      <= 1'b0;
      for (int unsigned k = 0; k < N_CAND; k++) cnt_q[k] <= '0;
    end else begin
      prev_q     <= i_candidate;
      o_vote_ack <= accept;
      o_reject   <= reject;
      o_valid    <= (state_q == StFinish) && i_voting_over;
      hold_q     <= (state_q == StHold) ? hold_q + HOLD_W'(1) : '0;
      for (int unsigned k = 0; k < N_CAND; k++) begin
        if (state_q == StIdle) begin
          cnt_q[k] <= '0;
        end else if (accept && fall[k] && (cnt_q[k] != '1)) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
      if (load) begin
        for (int unsigned k = 0; k < N_CAND; k++) o_count[k*CNT_W +: CNT_W] <= cnt_q[k];
        o_total  <= sum;
        o_winner <= win_idx;
        o_tie    <= tie;
      end
    end
  end

endmodule

// File: tb/tb_voting_machine_n.sv
// Scoreboard bench for voting_machine_n: expected pulses and published results
// are queued as stimulus is driven and checked when the DUT produces them.
module tb_voting_machine_n;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int HC = 16;
  localparam int IW = 2;
  localparam int TW = CW + IW;

  localparam int EV_ACK = 1;
  localparam int EV_REJ = 2;

  typedef struct packed {
    logic [N*CW-1:0] cnt;
    logic [TW-1:0]   tot;
    logic [IW-1:0]   win;
    logic            tie;
  } res_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    cand;
  logic            over;
  logic [N*CW-1:0] o_count;
  logic [TW-1:0]   o_total;
  logic [IW-1:0]   o_winner;
  logic            o_tie, o_valid, o_vote_ack, o_reject;
  logic [1:0]      o_state;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   ev_q[$];
  res_t res_q[$];
  int   exp_cnt[N];
  logic valid_prev = 1'b0;
  int   obs, ev;
  res_t r;

  voting_machine_n #(.N_CAND(N), .CNT_W(CW), .HOLD_CYC(HC)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_candidate  (cand),
    .i_voting_over(over),
    .o_count      (o_count),
    .o_total      (o_total),
    .o_winner     (o_winner),
    .o_tie        (o_tie),
    .o_valid      (o_valid),
    .o_vote_ack   (o_vote_ack),
    .o_reject     (o_reject),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Pulse and result monitor; all outputs change on posedge, sampled here.
  always @(negedge clk) begin
    if (o_vote_ack || o_reject) begin
      obs = o_vote_ack ? (o_reject ? 3 : EV_ACK) : EV_REJ;
      if (ev_q.size() == 0) check_eq("unexpected_pulse", obs, 0);
      else begin
        ev = ev_q.pop_front();
        check_eq("pulse_kind", obs, ev);
      end
    end
    if (o_valid && !valid_prev) begin
      if (res_q.size() == 0) check_eq("unexpected_valid", o_valid, 0);
      else begin
        r = res_q.pop_front();
        check_eq("count", o_count, r.cnt);
        check_eq("total", o_total, r.tot);
        check_eq("winner", o_winner, r.win);
        check_eq("tie", o_tie, r.tie);
      end
    end
    valid_prev = o_valid;
  end

  task automatic push_result();
    res_t e;
    int mx, nmax;
    e = '0;
    mx = 0;
    for (int k = 0; k < N; k++) if (exp_cnt[k] > mx) mx = exp_cnt[k];
    nmax = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (exp_cnt[k] == mx) begin
        nmax++;
        e.win = IW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      e.cnt[k*CW +: CW] = CW'(exp_cnt[k]);
      e.tot = e.tot + TW'(exp_cnt[k]);
    end
    e.tie = (nmax > 1);
    res_q.push_back(e);
  endtask

  task automatic vote(input int k);
    ev_q.push_back(EV_ACK);
    if (exp_cnt[k] < (1 << CW) - 1) exp_cnt[k]++;
    cand[k] = 1'b1;
    steps(2);
    cand[k] = 1'b0;
    steps(HC + 4);
  endtask

  // Caller is at a negedge; over is raised here and sampled on the next posedge.
  task automatic close_vote();
    push_result();
    over = 1'b1;
    steps(1);
    check_eq("finish_state", o_state, 2'd3);
    check_eq("valid_latency", o_valid, 1'b0);
    steps(1);
    check_eq("valid_set", o_valid, 1'b1);
    steps(1);
    check_eq("result_consumed", res_q.size(), 0);
    check_eq("pulses_consumed", ev_q.size(), 0);
    over = 1'b0;
    steps(1);
    check_eq("idle_after_close", o_state, 2'd0);
    check_eq("valid_clear", o_valid, 1'b0);
    for (int k = 0; k < N; k++) exp_cnt[k] = 0;
    steps(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, o_state, 2'd0);
    check_eq({tag, "_count"}, o_count, '0);
    check_eq({tag, "_total"}, o_total, '0);
    check_eq({tag, "_winner"}, o_winner, '0);
    check_eq({tag, "_flags"}, {o_tie, o_valid, o_vote_ack, o_reject}, 4'b0);
  endtask

  initial begin
    int hold_cycles;
    rst  = 1'b1;
    cand = '0;
    over = 1'b0;
    for (int k = 0; k < N; k++) exp_cnt[k] = 0;
    steps(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    steps(2);

    // 1: basic counting
    vote(1); vote(1); vote(2); vote(1);
    close_vote();

    // 2: simultaneous release, then release while another button is held
    cand = 4'b1001;
    steps(2);
    ev_q.push_back(EV_REJ);
    cand = 4'b0000;
    steps(3);
    cand = 4'b0110;
    steps(2);
    ev_q.push_back(EV_REJ);
    cand = 4'b0010;
    steps(2);
    check_eq("vote_after_reject", o_state, 2'd1);
    // Release coinciding with close is not counted; all-zero gives tie at index 0.
    cand = 4'b0000;
    close_vote();

    // 3: presses during lockout are ignored; HOLD lasts HC cycles
    ev_q.push_back(EV_ACK);
    exp_cnt[0] = 1;
    cand[0] = 1'b1;
    steps(2);
    cand[0] = 1'b0;
    hold_cycles = 0;
    for (int c = 0; c < HC + 8; c++) begin
      @(negedge clk);
      if (o_state == 2'd2) hold_cycles++;
      if (c == 4) cand[1] = 1'b1;
      if (c == 6) cand[1] = 1'b0;
    end
    check_eq("hold_cycles", hold_cycles, HC);
    check_eq("vote_after_hold", o_state, 2'd1);
    close_vote();

    // 4: saturation at 2^CW-1
    for (int i = 0; i < 20; i++) vote(2);
    close_vote();

    // 5: shared maximum 2/2/0/1
    vote(0); vote(1); vote(1); vote(0); vote(3);
    close_vote();

    // 6: reset in the middle of HOLD
    vote(0); vote(0);
    ev_q.push_back(EV_ACK);
    cand[1] = 1'b1;
    steps(2);
    cand[1] = 1'b0;
    steps(6);
    check_eq("hold_before_reset", o_state, 2'd2);
    rst = 1'b1;
    steps(1);
    check_reset_outputs("mid_hold_reset");
    rst = 1'b0;
    for (int k = 0; k < N; k++) exp_cnt[k] = 0;
    steps(2);
    vote(3);
    close_vote();

    check_eq("final_pulses", ev_q.size(), 0);
    check_eq("final_results", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voting_machine_n.md
Name: voting_machine_n

Overview:
- Parametrised N-candidate successor of the 3-candidate voting FSM.
- Counts one vote per button release. Rejects simultaneous or overlapping presses. Enforces a programmable lockout after each accepted vote. Saturates counters.
- At close of voting it publishes per-candidate totals, grand total, winner index and tie flag.
- Sits between debounced candidate push-buttons and the result display/readout logic.

Parameters:
- N_CAND, 4, number of candidates (>=2).
- CNT_W, 16, width of each per-candidate vote counter.
- HOLD_CYC, 16, lockout cycles spent in HOLD after an accepted vote (>=1).
- Derived, not overridable: IDX_W = max(1, clog2(N_CAND)); TOT_W = CNT_W + IDX_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_candidate  in  N_CAND  one button per candidate; bit k = candidate k.
- i_voting_over  in  1  high = close voting and publish results.
- o_count  out  N_CAND*CNT_W  published counts; candidate k at bits [k*CNT_W +: CNT_W].
- o_total  out  TOT_W  sum of published counts.
- o_winner  out  IDX_W  lowest index holding the maximum published count.
- o_tie  out  1  two or more candidates share the maximum.
- o_valid  out  1  published results are current for this election.
- o_vote_ack  out  1  one-cycle pulse when a vote is accepted.
- o_reject  out  1  one-cycle pulse when a release is rejected.
- o_state  out  2  FSM state: IDLE=0, VOTE=1, HOLD=2, FINISH=3.

Behaviour:
- Reset (sampled high on a clk edge):
  - state goes to IDLE; internal counters, hold counter and prev-input register go to 0.
  - o_count, o_total, o_winner, o_tie, o_valid, o_vote_ack and o_reject all go to 0.
  - Reset overrides everything, including mid-HOLD and mid-FINISH.
- prev-input register:
  - Samples i_candidate every non-reset cycle in all states.
  - Falling edge on bit k: prev[k]=1 and i_candidate[k]=0.
- IDLE:
  - Internal counters are cleared.
  - Moves to VOTE on the next edge when i_voting_over=0; otherwise stays in IDLE.
- VOTE, in priority order:
  1. i_voting_over=1: go to FINISH. Any release in the same cycle is not counted and not acked.
  2. Exactly one falling edge, and all i_candidate bits are 0: counter[k] increments (saturates at 2^CNT_W-1); o_vote_ack pulses on the next cycle; go to HOLD.
  3. Any falling edge that fails rule 2 (two or more simultaneous releases, or a release while another button is still high): nothing is counted; o_reject pulses on the next cycle; stay in VOTE.
  4. Otherwise: stay in VOTE.
- HOLD:
  - Lasts exactly HOLD_CYC cycles, then returns to VOTE.
  - Falling edges during HOLD are ignored: no count, no ack, no reject.
  - i_voting_over=1 exits to FINISH immediately.
- FINISH:
  - On the first edge in FINISH, register the outputs and set o_valid=1:
    - o_count takes the internal counters.
    - o_total takes the sum.
    - o_winner takes the lowest index among the maxima.
    - o_tie is 1 when the maximum is shared, including the all-zero case.
  - Stays in FINISH while i_voting_over=1.
  - i_voting_over=0 moves to IDLE; o_valid clears on that transition.
  - o_count, o_total, o_winner and o_tie hold their values until the next FINISH load or reset.
- Latency:
  - i_voting_over sampled high at edge E0 gives state FINISH after E0 and o_valid=1 after E1.
  - A release sampled at edge E0 gives the counter update and the o_vote_ack pulse after E0.
- Width rules:
  - Counters saturate and never wrap.
  - o_total cannot overflow because TOT_W is sized for N_CAND full counters.
  - Winner comparison is unsigned.

Test Plan:
1. Reset, release rst, 3 presses/releases of cand1 and 1 of cand2, each spaced >HOLD_CYC, then over=1 -> o_count[1]=3, o_count[2]=1, others 0, o_total=4, o_winner=1, o_tie=0, o_valid=1 two edges after over is sampled; 4 o_vote_ack pulses.
2. Cand0 and cand3 released in the same cycle; then cand2 released while cand1 is held high -> two o_reject pulses, all counts 0, state stays VOTE.
3. Cand0 released, then cand1 pressed/released 5 cycles later with HOLD_CYC=16 -> only cand0 counted, state shows HOLD for exactly 16 cycles, no reject.
4. CNT_W=4: 20 accepted votes for cand2 -> o_count[2]=15, no wrap.
5. Equal votes 2/2/0/1 -> o_winner=0, o_tie=1; zero votes -> o_winner=0, o_tie=1, o_total=0.
6. rst asserted mid-HOLD with nonzero counts -> next cycle state=IDLE, all outputs 0; a following election starts from zero counts.
